// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared pipeline definitions: stall-sequencer FSM states and the
// hard-wired zero register that never creates a load-use dependency.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_IFILL = 3'd1,
        ST_DFILL = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam logic [3:0] REG_ZERO = 4'h0;

endpackage : pipeline_stall_ctrl_pkg

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use comparator: flags when the instruction in ID reads a register
// that the load currently in EX has not yet written back.
module hazard_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic [3:0] id_src1_i,
    input  logic [3:0] id_src2_i,
    input  logic       id_uses_src1_i,
    input  logic       id_uses_src2_i,
    input  logic [3:0] ex_dst_i,
    input  logic       ex_is_load_i,
    output logic       load_use_o
);

    logic src1_match;
    logic src2_match;

    assign src1_match = id_uses_src1_i && (id_src1_i == ex_dst_i);
    assign src2_match = id_uses_src2_i && (id_src2_i == ex_dst_i);

    // A load into the zero register writes nothing, so it cannot cause a hazard.
    assign load_use_o = ex_is_load_i && (ex_dst_i != REG_ZERO) && (src1_match || src2_match);

endmodule : hazard_detect

// File: rtl/pipeline_stall_ctrl.sv
// Central hazard/stall sequencer for the five-stage pipeline: Mealy stall
// and flush controls, Moore memory-port grants, HLT drain and a saturating
// stall-cycle counter.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_srcReg1,
    input  logic [3:0]       id_srcReg2,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             id_is_hlt,
    input  logic             br_taken,
    input  logic [3:0]       ex_dstReg,
    input  logic             ex_is_load,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    input  logic             icache_fill_done,
    input  logic             dcache_fill_done,
    output logic             pc_wen,
    output logic             fd_wen,
    output logic             fd_flush,
    output logic             de_stall_en,
    output logic             de_d_cache_miss,
    output logic             xm_wen,
    output logic             mw_wen,
    output logic             mem_grant_i,
    output logic             mem_grant_d,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic             load_use;
    logic             stall_cnt_en;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic             drain_fill_q, drain_fill_d;
    logic             grant_i_q, grant_i_d;
    logic             grant_d_q, grant_d_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    hazard_detect u_hazard_detect (
        .id_src1_i      (id_srcReg1),
        .id_src2_i      (id_srcReg2),
        .id_uses_src1_i (id_uses_src1),
        .id_uses_src2_i (id_uses_src2),
        .ex_dst_i       (ex_dstReg),
        .ex_is_load_i   (ex_is_load),
        .load_use_o     (load_use)
    );

    // Pipeline-register controls, prioritised: D-miss freeze, load-use, I-miss, branch.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        pc_wen          = 1'b1;
        fd_wen          = 1'b1;
        fd_flush        = 1'b0;
        de_stall_en     = 1'b0;
        de_d_cache_miss = 1'b0;
        xm_wen          = 1'b1;
        mw_wen          = 1'b1;
        unique case (state_q)
            ST_RUN, ST_IFILL, ST_DFILL: begin
                if (dcache_miss || state_q == ST_DFILL) begin
                    pc_wen          = 1'b0;
                    fd_wen          = 1'b0;
                    xm_wen          = 1'b0;
                    mw_wen          = 1'b0;
                    de_stall_en     = 1'b1;
                    de_d_cache_miss = 1'b1;
                end else if (load_use) begin
                    pc_wen      = 1'b0;
                    fd_wen      = 1'b0;
                    de_stall_en = 1'b1;
                end else if (icache_miss || state_q == ST_IFILL) begin
                    pc_wen   = 1'b0;
                    fd_flush = 1'b1;
                end else if (br_taken) begin
                    fd_flush = 1'b1;
                end
            end
            ST_DRAIN: begin
                pc_wen   = 1'b0;
                fd_flush = 1'b1;
                // A D-miss while draining freezes the back end until its fill lands.
                if (dcache_miss || drain_fill_q) begin
                    fd_wen          = 1'b0;
                    xm_wen          = 1'b0;
                    mw_wen          = 1'b0;
                    de_stall_en     = 1'b1;
                    de_d_cache_miss = 1'b1;
                end
            end
            ST_HALT: begin
                pc_wen   = 1'b0;
                fd_wen   = 1'b0;
                xm_wen   = 1'b0;
                mw_wen   = 1'b0;
                fd_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Next state, drain countdown and the grants that follow the next state.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        drain_fill_d = drain_fill_q;
        unique case (state_q)
            ST_RUN: begin
                if (dcache_miss) begin
                    state_d = ST_DFILL;
                end else if (icache_miss) begin
                    state_d = ST_IFILL;
                end else if (id_is_hlt && !load_use) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DW'(DRAIN_CYCLES - 1);
                end
            end
            ST_IFILL: begin
                if (icache_fill_done) begin
                    state_d = dcache_miss ? ST_DFILL : ST_RUN;
                end
            end
            ST_DFILL: begin
                if (dcache_fill_done) begin
                    state_d = icache_miss ? ST_IFILL : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_fill_q) begin
                    if (dcache_fill_done) begin
                        drain_fill_d = 1'b0;
                    end
                end else if (dcache_miss) begin
                    drain_fill_d = 1'b1;
                end else if (drain_cnt_q == '0) begin
                    state_d = ST_HALT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                end
            end
            ST_HALT: ;
            default: state_d = ST_RUN;
        endcase

        grant_i_d = (state_d == ST_IFILL);
        grant_d_d = (state_d == ST_DFILL) || (state_d == ST_DRAIN && drain_fill_d);
    end

    // Saturating stall counter: only cycles lost while the pipeline is live count.
    always_comb begin
        stall_cnt_en = !pc_wen && (state_q == ST_RUN || state_q == ST_IFILL || state_q == ST_DFILL);
        stall_d      = (stall_cnt_en && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
    end

    // State register; reset aborts any fill and drops the grants asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= '0;
            drain_fill_q <= 1'b0;
            grant_i_q    <= 1'b0;
            grant_d_q    <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            drain_fill_q <= drain_fill_d;
            grant_i_q    <= grant_i_d;
            grant_d_q    <= grant_d_d;
            stall_q      <= stall_d;
        end
    end

    assign mem_grant_i  = grant_i_q;
    assign mem_grant_d  = grant_d_q;
    assign halted       = (state_q == ST_HALT);
    assign stall_cycles = stall_q;

endmodule : pipeline_stall_ctrl

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a vector table for the RUN-state
// combinational controls, then hand sequences for fills, drain, saturation
// and asynchronous reset.
module tb_pipeline_stall_ctrl;

    // {pc_wen, fd_wen, fd_flush, de_stall_en, de_d_cache_miss, xm_wen, mw_wen}
    localparam logic [6:0] CTL_RUN   = 7'b1100011;
    localparam logic [6:0] CTL_LU    = 7'b0001011;
    localparam logic [6:0] CTL_BR    = 7'b1110011;
    localparam logic [6:0] CTL_FRZ   = 7'b0001100;
    localparam logic [6:0] CTL_IMISS = 7'b0110011;
    localparam logic [6:0] CTL_DRAIN = 7'b0110011;
    localparam logic [6:0] CTL_DRFRZ = 7'b0011100;
    localparam logic [6:0] CTL_HALT  = 7'b0010000;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_srcReg1, id_srcReg2, ex_dstReg;
    logic        id_uses_src1, id_uses_src2, id_is_hlt, br_taken, ex_is_load;
    logic        icache_miss, dcache_miss, icache_fill_done, dcache_fill_done;

    logic        pc_wen, fd_wen, fd_flush, de_stall_en, de_d_cache_miss, xm_wen, mw_wen;
    logic        mem_grant_i, mem_grant_d, halted;
    logic [15:0] stall_cycles;

    logic        pc_wen2, fd_wen2, fd_flush2, de_stall_en2, de_d_cache_miss2, xm_wen2, mw_wen2;
    logic        mem_grant_i2, mem_grant_d2, halted2;
    logic [3:0]  stall_cycles2;

    logic [6:0]  ctl;
    assign ctl = {pc_wen, fd_wen, fd_flush, de_stall_en, de_d_cache_miss, xm_wen, mw_wen};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.DRAIN_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_srcReg1(id_srcReg1), .id_srcReg2(id_srcReg2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .id_is_hlt(id_is_hlt), .br_taken(br_taken),
        .ex_dstReg(ex_dstReg), .ex_is_load(ex_is_load),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss),
        .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
        .pc_wen(pc_wen), .fd_wen(fd_wen), .fd_flush(fd_flush),
        .de_stall_en(de_stall_en), .de_d_cache_miss(de_d_cache_miss),
        .xm_wen(xm_wen), .mw_wen(mw_wen),
        .mem_grant_i(mem_grant_i), .mem_grant_d(mem_grant_d),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    pipeline_stall_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_srcReg1(id_srcReg1), .id_srcReg2(id_srcReg2),
        .id_uses_src1(id_uses_src1), .id_uses_src2(id_uses_src2),
        .id_is_hlt(id_is_hlt), .br_taken(br_taken),
        .ex_dstReg(ex_dstReg), .ex_is_load(ex_is_load),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss),
        .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
        .pc_wen(pc_wen2), .fd_wen(fd_wen2), .fd_flush(fd_flush2),
        .de_stall_en(de_stall_en2), .de_d_cache_miss(de_d_cache_miss2),
        .xm_wen(xm_wen2), .mw_wen(mw_wen2),
        .mem_grant_i(mem_grant_i2), .mem_grant_d(mem_grant_d2),
        .halted(halted2), .stall_cycles(stall_cycles2)
    );

    typedef struct {
        string      name;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       use1;
        logic       use2;
        logic       hlt;
        logic       br;
        logic [3:0] exdst;
        logic       exload;
        logic [6:0] exp_ctl;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_cyc(input string name, input logic [6:0] exp_ctl,
                             input logic exp_gi, input logic exp_gd);
        check({name, " ctl"}, 32'(ctl), 32'(exp_ctl));
        check({name, " grants"}, {30'd0, mem_grant_i, mem_grant_d}, {30'd0, exp_gi, exp_gd});
    endtask

    task automatic clear_inputs();
        id_srcReg1 = 4'd0; id_srcReg2 = 4'd0; id_uses_src1 = 1'b0; id_uses_src2 = 1'b0;
        id_is_hlt = 1'b0; br_taken = 1'b0; ex_dstReg = 4'd0; ex_is_load = 1'b0;
        icache_miss = 1'b0; dcache_miss = 1'b0;
        icache_fill_done = 1'b0; dcache_fill_done = 1'b0;
    endtask

    // Inputs change at posedge+1; checks run at posedge+3.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_load_use();
        ex_is_load = 1'b1; ex_dstReg = 4'd3; id_srcReg2 = 4'd3; id_uses_src2 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{"idle",          4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, CTL_RUN};
        vecs[1]  = '{"lu_src2",       4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1, CTL_LU};
        vecs[2]  = '{"lu_r0",         4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, CTL_RUN};
        vecs[3]  = '{"lu_src2_unused",4'd0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1, CTL_RUN};
        vecs[4]  = '{"lu_src1",       4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, CTL_LU};
        vecs[5]  = '{"no_load",       4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, CTL_RUN};
        vecs[6]  = '{"branch",        4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, CTL_BR};
        vecs[7]  = '{"branch_lu",     4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 1'b1, CTL_LU};
        vecs[8]  = '{"hlt_lu",        4'd6, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 1'b1, CTL_LU};
        vecs[9]  = '{"after_hlt_lu",  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, CTL_RUN};
        vecs[10] = '{"lu_src2_only",  4'd7, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 1'b1, CTL_LU};
        vecs[11] = '{"lu_nomatch",    4'd3, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, CTL_RUN};

        // Reset state
        clear_inputs();
        rst = 1'b1;
        #3;
        check_cyc("reset", CTL_RUN, 1'b0, 1'b0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset stall", 32'(stall_cycles), 32'd0);
        do_reset();

        // Combinational table in RUN; stalled vectors: 1, 4, 7, 8, 10
        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            id_srcReg1 = vecs[i].src1; id_srcReg2 = vecs[i].src2;
            id_uses_src1 = vecs[i].use1; id_uses_src2 = vecs[i].use2;
            id_is_hlt = vecs[i].hlt; br_taken = vecs[i].br;
            ex_dstReg = vecs[i].exdst; ex_is_load = vecs[i].exload;
            #2;
            check_cyc(vecs[i].name, vecs[i].exp_ctl, 1'b0, 1'b0);
            next_cycle();
        end
        clear_inputs();
        #2;
        check("table stall count", 32'(stall_cycles), 32'd5);

        // D-miss for 8 cycles, fill_done on the 8th
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            dcache_miss = 1'b1;
            dcache_fill_done = (k == 8);
            #2;
            check_cyc($sformatf("dmiss c%0d", k), CTL_FRZ, 1'b0, k >= 2);
            next_cycle();
        end
        clear_inputs();
        #2;
        check_cyc("dmiss done", CTL_RUN, 1'b0, 1'b0);
        check("dmiss stall count", 32'(stall_cycles), 32'd8);

        // Simultaneous misses: D served first, then I; stray dcache_fill_done in IFILL ignored
        do_reset();
        icache_miss = 1'b1; dcache_miss = 1'b1;
        #2; check_cyc("dual c1", CTL_FRZ, 1'b0, 1'b0);
        next_cycle(); #2; check_cyc("dual c2", CTL_FRZ, 1'b0, 1'b1);
        next_cycle(); #2; check_cyc("dual c3", CTL_FRZ, 1'b0, 1'b1);
        next_cycle(); dcache_fill_done = 1'b1;
        #2; check_cyc("dual c4", CTL_FRZ, 1'b0, 1'b1);
        next_cycle(); dcache_fill_done = 1'b1; dcache_miss = 1'b0;
        #2; check_cyc("dual c5 ifill", CTL_IMISS, 1'b1, 1'b0);
        next_cycle(); dcache_fill_done = 1'b0; icache_fill_done = 1'b1;
        #2; check_cyc("dual c6 ifill", CTL_IMISS, 1'b1, 1'b0);
        next_cycle(); clear_inputs();
        #2; check_cyc("dual c7 run", CTL_RUN, 1'b0, 1'b0);

        // HLT drain, no miss
        do_reset();
        id_is_hlt = 1'b1;
        #2; check_cyc("hlt c0", CTL_RUN, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle(); clear_inputs();
            #2;
            check_cyc($sformatf("drain c%0d", k), CTL_DRAIN, 1'b0, 1'b0);
            check($sformatf("drain c%0d halted", k), 32'(halted), 32'd0);
        end
        next_cycle(); #2;
        check_cyc("halt", CTL_HALT, 1'b0, 1'b0);
        check("halt halted", 32'(halted), 32'd1);
        check("halt stall count", 32'(stall_cycles), 32'd0);

        // HLT drain with a 3-cycle D-miss: halted moves from cycle 5 to cycle 8
        do_reset();
        id_is_hlt = 1'b1;
        next_cycle(); clear_inputs();
        #2; check_cyc("dr c1", CTL_DRAIN, 1'b0, 1'b0);
        next_cycle(); dcache_miss = 1'b1;
        #2; check_cyc("dr c2 miss", CTL_DRFRZ, 1'b0, 1'b0);
        next_cycle();
        #2; check_cyc("dr c3 miss", CTL_DRFRZ, 1'b0, 1'b1);
        next_cycle(); dcache_fill_done = 1'b1;
        #2; check_cyc("dr c4 done", CTL_DRFRZ, 1'b0, 1'b1);
        for (int k = 5; k <= 7; k++) begin
            next_cycle(); clear_inputs();
            #2;
            check_cyc($sformatf("dr c%0d", k), CTL_DRAIN, 1'b0, 1'b0);
            check($sformatf("dr c%0d halted", k), 32'(halted), 32'd0);
        end
        next_cycle(); #2;
        check("dr c8 halted", 32'(halted), 32'd1);

        // Saturation: 20 load-use cycles into a 4-bit counter
        do_reset();
        for (int k = 0; k < 20; k++) begin
            set_load_use();
            next_cycle();
        end
        clear_inputs();
        #2;
        check("sat narrow", 32'(stall_cycles2), 32'hF);
        check("sat wide", 32'(stall_cycles), 32'd20);
        set_load_use();
        next_cycle(); clear_inputs(); #2;
        check("sat narrow hold", 32'(stall_cycles2), 32'hF);

        // Reset in the middle of IFILL
        do_reset();
        icache_miss = 1'b1;
        #2; check_cyc("ifill c1", CTL_IMISS, 1'b0, 1'b0);
        next_cycle();
        #2; check_cyc("ifill c2", CTL_IMISS, 1'b1, 1'b0);
        clear_inputs();
        rst = 1'b1;
        #1;
        check_cyc("async rst", CTL_RUN, 1'b0, 1'b0);
        check("async rst stall", 32'(stall_cycles), 32'd0);
        check("async rst halted", 32'(halted), 32'd0);
        next_cycle(); rst = 1'b0;
        next_cycle(); #2;
        check_cyc("after rst", CTL_RUN, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_stall_ctrl
